nasti_stream_fifo: RTL and testbench



---
 rtl/nasti_stream_pkg.sv | 25 ++
 rtl/nasti_stream_channel.sv | 28 ++
 rtl/nasti_stream_fifo_mem.sv | 27 ++
 rtl/nasti_stream_fifo.sv | 117 +++++++++++
 tb/tb_nasti_stream_fifo.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nasti_stream_pkg.sv
// Shared helpers for the NASTI-stream FIFO: ring pointer advance, level width
// and parameter sanity checks.
package nasti_stream_pkg;

    localparam int unsigned MIN_BUF_SIZE = 2;

    // Ring pointer advance that wraps for any depth, not just powers of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned size);
        return (ptr + 1 >= size) ? 0 : ptr + 1;
    endfunction

    // Enough bits to hold every value 0..size inclusive.
    function automatic int unsigned level_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

    function automatic bit cfg_ok(input int unsigned buf_size,
                                  input int unsigned afull_thresh,
                                  input int unsigned aempty_thresh);
        return (buf_size >= MIN_BUF_SIZE) &&
               (afull_thresh <= buf_size) &&
               (aempty_thresh <= buf_size);
    endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// NASTI stream channel bundle: one valid/ready handshake carrying a beat.
interface nasti_stream_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int DATA_WIDTH = 64
);
    logic                      t_valid;
    logic                      t_ready;
    logic [DATA_WIDTH-1:0]     t_data;
    logic [DATA_WIDTH/8-1:0]   t_strb;
    logic [DATA_WIDTH/8-1:0]   t_keep;
    logic                      t_last;
    logic [ID_WIDTH-1:0]       t_id;
    logic [DEST_WIDTH-1:0]     t_dest;
    logic [USER_WIDTH-1:0]     t_user;

    modport master (
        output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        input  t_ready
    );

    modport slave (
        input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
        output t_ready
    );

endinterface

// File: rtl/nasti_stream_fifo_mem.sv
// Payload storage: DEPTH x WIDTH register array, one synchronous write port and
// one asynchronous read port so the head entry falls through to the output.
module nasti_stream_fifo_mem #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents need no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nasti_stream_fifo.sv
// Parametrised NASTI-stream FIFO: arbitrary depth ring, optional store-and-forward
// packet mode, fill level / packet count status and a synchronous flush.
module nasti_stream_fifo
    import nasti_stream_pkg::*;
#(
    parameter  int ID_WIDTH      = 1,
    parameter  int DEST_WIDTH    = 1,
    parameter  int USER_WIDTH    = 1,
    parameter  int DATA_WIDTH    = 64,
    parameter  int BUF_SIZE      = 8,
    parameter  int PACKET_MODE   = 0,
    parameter  int AFULL_THRESH  = BUF_SIZE - 1,
    parameter  int AEMPTY_THRESH = 1,
    localparam int LW            = level_width(BUF_SIZE)
) (
    input  logic                  aclk,
    input  logic                  areset,
    nasti_stream_channel.slave    src,
    nasti_stream_channel.master   dest,
    input  logic                  flush,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         pkt_count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int PW        = $clog2(BUF_SIZE);
    localparam int SW        = DATA_WIDTH / 8;
    localparam int PAYLOAD_W = DATA_WIDTH + 2 * SW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(BUF_SIZE);

    if (!cfg_ok(BUF_SIZE, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_cfg
        $error("nasti_stream_fifo: BUF_SIZE must be >= 2 and thresholds within 0..BUF_SIZE");
    end

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PAYLOAD_W-1:0] wr_payload;
    logic [PAYLOAD_W-1:0] rd_payload;
    logic                 full;
    logic                 empty;
    logic                 release_ok;
    logic                 w_fire;
    logic                 r_fire;
    logic                 w_last;
    logic                 r_last;

    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // Handshake: a beat moves on an edge where valid and ready are both high.
    // ready never looks at the downstream ready, and valid never looks at the
    // upstream valid, so no combinational path crosses the FIFO.
    assign src.t_ready = !areset && !flush && !full;

    // In packet mode a beat is only offered once a whole packet is held, except
    // when the ring is full: then cut-through is the only way to make progress.
    assign release_ok  = (PACKET_MODE == 0) || (pkt_count != '0) || full;
    assign dest.t_valid = !flush && !empty && release_ok;

    assign w_fire = src.t_valid && src.t_ready;
    assign r_fire = dest.t_valid && dest.t_ready;
    assign w_last = w_fire && src.t_last;
    assign r_last = r_fire && dest.t_last;

    assign wr_payload = {src.t_data, src.t_strb, src.t_keep, src.t_last,
                         src.t_id, src.t_dest, src.t_user};
    assign {dest.t_data, dest.t_strb, dest.t_keep, dest.t_last,
            dest.t_id, dest.t_dest, dest.t_user} = rd_payload;

    nasti_stream_fifo_mem #(
        .DEPTH (BUF_SIZE),
        .WIDTH (PAYLOAD_W)
    ) u_mem (
        .clk   (aclk),
        .we    (w_fire),
        .waddr (wr_ptr),
        .wdata (wr_payload),
        .raddr (rd_ptr),
        .rdata (rd_payload)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            pkt_count <= '0;
        end else begin
            if (w_fire) begin
                wr_ptr <= PW'(next_ptr(32'(wr_ptr), BUF_SIZE));
            end
            if (r_fire) begin
                rd_ptr <= PW'(next_ptr(32'(rd_ptr), BUF_SIZE));
            end
            if (w_fire && !r_fire) begin
                level <= level + LW'(1);
            end else if (!w_fire && r_fire) begin
                level <= level - LW'(1);
            end
            if (w_last && !r_last) begin
                pkt_count <= pkt_count + LW'(1);
            end else if (!w_last && r_last) begin
                pkt_count <= pkt_count - LW'(1);
            end
        end
    end

    assign almost_full  = (level >= LW'(AFULL_THRESH));
    assign almost_empty = (level <= LW'(AEMPTY_THRESH));

endmodule

// File: tb/tb_nasti_stream_fifo.sv
// Bench for nasti_stream_fifo: a streaming instance (depth 5) and a packet-mode
// instance (depth 4) checked against a queue-based model of the stream.
module tb_nasti_stream_fifo;

    localparam int S_BUF = 5;
    localparam int P_BUF = 4;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  dest;
        logic [3:0]  user;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    logic       s_flush, p_flush;
    logic [2:0] s_level, s_pkt, p_level, p_pkt;
    logic       s_af, s_ae, p_af, p_ae;

    nasti_stream_channel #(.ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64)) s_src ();
    nasti_stream_channel #(.ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64)) s_dst ();
    nasti_stream_channel #(.ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64)) p_src ();
    nasti_stream_channel #(.ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64)) p_dst ();

    nasti_stream_fifo #(
        .ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64),
        .BUF_SIZE(S_BUF), .PACKET_MODE(0)
    ) u_stream (
        .aclk(clk), .areset(areset), .src(s_src), .dest(s_dst), .flush(s_flush),
        .level(s_level), .pkt_count(s_pkt), .almost_full(s_af), .almost_empty(s_ae)
    );

    nasti_stream_fifo #(
        .ID_WIDTH(4), .DEST_WIDTH(2), .USER_WIDTH(4), .DATA_WIDTH(64),
        .BUF_SIZE(P_BUF), .PACKET_MODE(1)
    ) u_packet (
        .aclk(clk), .areset(areset), .src(p_src), .dest(p_dst), .flush(p_flush),
        .level(p_level), .pkt_count(p_pkt), .almost_full(p_af), .almost_empty(p_ae)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [BEAT_W-1:0] exp_q[$];

    // ---------------- helpers / drivers ----------------
    function automatic beat_t mk_beat(input int i, input logic last);
        beat_t b;
        b.data = 64'hD000_0000_0000_0000 | 64'(i);
        b.strb = '1;
        b.keep = '1;
        b.last = last;
        b.id   = 4'(i);
        b.dest = 2'(i);
        b.user = 4'(~i);
        return b;
    endfunction

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.strb = 8'($urandom);
        b.keep = 8'($urandom);
        b.last = last;
        b.id   = 4'($urandom);
        b.dest = 2'($urandom);
        b.user = 4'($urandom);
        return b;
    endfunction

    function automatic int count_lasts();
        int n = 0;
        beat_t b;
        foreach (exp_q[i]) begin
            b = exp_q[i];
            if (b.last) n++;
        end
        return n;
    endfunction

    task automatic s_drive(input logic v, input beat_t b);
        s_src.t_valid = v;
        s_src.t_data  = b.data;
        s_src.t_strb  = b.strb;
        s_src.t_keep  = b.keep;
        s_src.t_last  = b.last;
        s_src.t_id    = b.id;
        s_src.t_dest  = b.dest;
        s_src.t_user  = b.user;
    endtask

    task automatic p_drive(input logic v, input beat_t b);
        p_src.t_valid = v;
        p_src.t_data  = b.data;
        p_src.t_strb  = b.strb;
        p_src.t_keep  = b.keep;
        p_src.t_last  = b.last;
        p_src.t_id    = b.id;
        p_src.t_dest  = b.dest;
        p_src.t_user  = b.user;
    endtask

    function automatic beat_t s_obs();
        return {s_dst.t_data, s_dst.t_strb, s_dst.t_keep, s_dst.t_last,
                s_dst.t_id, s_dst.t_dest, s_dst.t_user};
    endfunction

    function automatic beat_t p_obs();
        return {p_dst.t_data, p_dst.t_strb, p_dst.t_keep, p_dst.t_last,
                p_dst.t_id, p_dst.t_dest, p_dst.t_user};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (s_src.t_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b expected 0", s_src.t_ready); end
        checks++; if (s_dst.t_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid: got %b expected 0", s_dst.t_valid); end
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL reset_s_level: got %0d expected 0", s_level); end
        checks++; if (s_ae !== 1'b1) begin failures++; $display("FAIL reset_s_aempty: got %b expected 1", s_ae); end
        checks++; if (s_af !== 1'b0) begin failures++; $display("FAIL reset_s_afull: got %b expected 0", s_af); end
        checks++; if (p_src.t_ready !== 1'b0) begin failures++; $display("FAIL reset_p_ready: got %b expected 0", p_src.t_ready); end
        checks++; if (p_pkt !== 3'd0) begin failures++; $display("FAIL reset_p_pkt: got %0d expected 0", p_pkt); end
        @(negedge clk);
        areset = 1'b0;
        #1;
        checks++; if (s_src.t_ready !== 1'b1) begin failures++; $display("FAIL post_reset_s_ready: got %b expected 1", s_src.t_ready); end
    endtask

    task automatic test_fill_drain();
        beat_t obs;
        s_dst.t_ready = 1'b0;
        for (int i = 0; i < S_BUF; i++) begin
            @(negedge clk);
            s_drive(1'b1, mk_beat(i, i == S_BUF - 1));
            #1;
            checks++; if (s_src.t_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, s_src.t_ready); end
            checks++; if (s_level !== 3'(i)) begin failures++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, s_level, i); end
        end
        @(negedge clk);
        s_drive(1'b0, '0);
        #1;
        checks++; if (s_level !== 3'(S_BUF)) begin failures++; $display("FAIL full_level: got %0d expected %0d", s_level, S_BUF); end
        checks++; if (s_src.t_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %b expected 0", s_src.t_ready); end
        checks++; if (s_af !== 1'b1) begin failures++; $display("FAIL full_afull: got %b expected 1", s_af); end
        for (int i = 0; i < S_BUF; i++) begin
            @(negedge clk);
            s_dst.t_ready = 1'b1;
            #1;
            obs = s_obs();
            checks++; if (s_dst.t_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, s_dst.t_valid); end
            checks++; if (obs !== mk_beat(i, i == S_BUF - 1)) begin failures++; $display("FAIL drain_beat[%0d]: got %h expected %h", i, obs, mk_beat(i, i == S_BUF - 1)); end
            checks++; if (s_level !== 3'(S_BUF - i)) begin failures++; $display("FAIL drain_level[%0d]: got %0d expected %0d", i, s_level, S_BUF - i); end
            if (i < 2) begin
                checks++; if (s_src.t_ready !== (i == 1)) begin failures++; $display("FAIL drain_ready[%0d]: got %b expected %b", i, s_src.t_ready, i == 1); end
            end
        end
        @(negedge clk);
        s_dst.t_ready = 1'b0;
        #1;
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL drained_level: got %0d expected 0", s_level); end
        checks++; if (s_dst.t_valid !== 1'b0) begin failures++; $display("FAIL drained_valid: got %b expected 0", s_dst.t_valid); end
        checks++; if (s_ae !== 1'b1) begin failures++; $display("FAIL drained_aempty: got %b expected 1", s_ae); end
    endtask

    task automatic test_stream_random(input int n, input int vpct, input int rpct, input string tag);
        beat_t cur, obs, exp_b;
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        exp_q.delete();
        cur = rand_beat(1'($urandom_range(1)));
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            s_drive((sent < n) && ($urandom_range(99) < vpct), cur);
            s_dst.t_ready = ($urandom_range(99) < rpct);
            #1;
            checks++; if (s_level !== 3'(exp_q.size())) begin failures++; $display("FAIL %s level: got %0d expected %0d", tag, s_level, exp_q.size()); end
            checks++; if (s_dst.t_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL %s valid: got %b expected %b", tag, s_dst.t_valid, exp_q.size() != 0); end
            checks++; if (s_src.t_ready !== (exp_q.size() != S_BUF)) begin failures++; $display("FAIL %s ready: got %b expected %b", tag, s_src.t_ready, exp_q.size() != S_BUF); end
            checks++; if (s_af !== (exp_q.size() >= S_BUF - 1)) begin failures++; $display("FAIL %s afull: got %b level %0d", tag, s_af, exp_q.size()); end
            checks++; if (s_ae !== (exp_q.size() <= 1)) begin failures++; $display("FAIL %s aempty: got %b level %0d", tag, s_ae, exp_q.size()); end
            if (s_dst.t_valid === 1'b1 && exp_q.size() != 0) begin
                obs   = s_obs();
                exp_b = exp_q[0];
                checks++; if (obs !== exp_b) begin failures++; $display("FAIL %s beat[%0d]: got %h expected %h", tag, got, obs, exp_b); end
            end
            if (s_dst.t_valid === 1'b1 && s_dst.t_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (s_src.t_valid && s_src.t_ready === 1'b1) begin
                exp_q.push_back(cur);
                sent++;
                cur = rand_beat(1'($urandom_range(1)));
            end
            cyc++;
        end
        checks++; if (got !== n) begin failures++; $display("FAIL %s delivered: got %0d expected %0d", tag, got, n); end
        @(negedge clk);
        s_drive(1'b0, '0);
        s_dst.t_ready = 1'b0;
        #1;
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL %s end_level: got %0d expected 0", tag, s_level); end
    endtask

    task automatic test_packet();
        beat_t obs;
        p_dst.t_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p_drive(1'b1, mk_beat(16 + k, k == 2));
            #1;
            checks++; if (p_dst.t_valid !== 1'b0) begin failures++; $display("FAIL pkt_hold_valid[%0d]: got %b expected 0", k, p_dst.t_valid); end
            checks++; if (p_pkt !== 3'd0) begin failures++; $display("FAIL pkt_hold_count[%0d]: got %0d expected 0", k, p_pkt); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p_drive(1'b0, '0);
            #1;
            obs = p_obs();
            checks++; if (p_dst.t_valid !== 1'b1) begin failures++; $display("FAIL pkt_out_valid[%0d]: got %b expected 1", k, p_dst.t_valid); end
            checks++; if (obs !== mk_beat(16 + k, k == 2)) begin failures++; $display("FAIL pkt_out_beat[%0d]: got %h expected %h", k, obs, mk_beat(16 + k, k == 2)); end
            checks++; if (p_pkt !== 3'd1) begin failures++; $display("FAIL pkt_out_count[%0d]: got %0d expected 1", k, p_pkt); end
        end
        @(negedge clk);
        p_dst.t_ready = 1'b0;
        #1;
        checks++; if (p_pkt !== 3'd0) begin failures++; $display("FAIL pkt_done_count: got %0d expected 0", p_pkt); end
        checks++; if (p_level !== 3'd0) begin failures++; $display("FAIL pkt_done_level: got %0d expected 0", p_level); end
    endtask

    task automatic test_oversize();
        beat_t obs;
        int sent = 0;
        int got  = 0;
        int first_lvl = -1;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            @(negedge clk);
            p_drive(sent < 6, mk_beat(32 + sent, sent == 5));
            p_dst.t_ready = 1'b1;
            #1;
            checks++; if (p_level > 3'(P_BUF)) begin failures++; $display("FAIL oversize_level: got %0d max %0d", p_level, P_BUF); end
            if (p_dst.t_valid === 1'b1) begin
                if (first_lvl < 0) first_lvl = int'(p_level);
                obs = p_obs();
                checks++; if (obs !== mk_beat(32 + got, got == 5)) begin failures++; $display("FAIL oversize_beat[%0d]: got %h expected %h", got, obs, mk_beat(32 + got, got == 5)); end
                got++;
            end
            if (p_src.t_valid && p_src.t_ready === 1'b1) sent++;
        end
        checks++; if (got !== 6) begin failures++; $display("FAIL oversize_delivered: got %0d expected 6", got); end
        checks++; if (first_lvl !== P_BUF) begin failures++; $display("FAIL oversize_release_level: got %0d expected %0d", first_lvl, P_BUF); end
        @(negedge clk);
        p_drive(1'b0, '0);
        p_dst.t_ready = 1'b0;
        #1;
        checks++; if (p_level !== 3'd0) begin failures++; $display("FAIL oversize_end_level: got %0d expected 0", p_level); end
    endtask

    task automatic test_packet_random(input int n_pkts);
        beat_t cur, obs, exp_b;
        int pkts_sent = 0;
        int left      = 0;
        int total     = 0;
        int got       = 0;
        int cyc       = 0;
        logic exp_valid;
        exp_q.delete();
        left = $urandom_range(5, 1);
        cur  = rand_beat(left == 1);
        while ((pkts_sent < n_pkts || exp_q.size() != 0) && cyc < 3000) begin
            @(negedge clk);
            p_drive((pkts_sent < n_pkts) && ($urandom_range(99) < 70), cur);
            p_dst.t_ready = ($urandom_range(99) < 60);
            #1;
            exp_valid = (exp_q.size() != 0) && (count_lasts() != 0 || exp_q.size() == P_BUF);
            checks++; if (p_level !== 3'(exp_q.size())) begin failures++; $display("FAIL prand level: got %0d expected %0d", p_level, exp_q.size()); end
            checks++; if (p_pkt !== 3'(count_lasts())) begin failures++; $display("FAIL prand pkt_count: got %0d expected %0d", p_pkt, count_lasts()); end
            checks++; if (p_dst.t_valid !== exp_valid) begin failures++; $display("FAIL prand valid: got %b expected %b", p_dst.t_valid, exp_valid); end
            checks++; if (p_af !== (exp_q.size() >= P_BUF - 1)) begin failures++; $display("FAIL prand afull: got %b level %0d", p_af, exp_q.size()); end
            if (p_dst.t_valid === 1'b1 && exp_q.size() != 0) begin
                obs   = p_obs();
                exp_b = exp_q[0];
                checks++; if (obs !== exp_b) begin failures++; $display("FAIL prand beat[%0d]: got %h expected %h", got, obs, exp_b); end
            end
            if (p_dst.t_valid === 1'b1 && p_dst.t_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                got++;
            end
            if (p_src.t_valid && p_src.t_ready === 1'b1) begin
                exp_q.push_back(cur);
                total++;
                left--;
                if (left == 0) begin
                    pkts_sent++;
                    left = $urandom_range(5, 1);
                end
                cur = rand_beat(left == 1);
            end
            cyc++;
        end
        checks++; if (got !== total) begin failures++; $display("FAIL prand delivered: got %0d expected %0d", got, total); end
        checks++; if (pkts_sent !== n_pkts) begin failures++; $display("FAIL prand packets: got %0d expected %0d", pkts_sent, n_pkts); end
        @(negedge clk);
        p_drive(1'b0, '0);
        p_dst.t_ready = 1'b0;
    endtask

    task automatic test_flush();
        p_dst.t_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            p_drive(1'b1, mk_beat(64 + k, k == 2));
        end
        @(negedge clk);
        p_drive(1'b0, '0);
        #1;
        checks++; if (p_level !== 3'd3) begin failures++; $display("FAIL flush_pre_level: got %0d expected 3", p_level); end
        checks++; if (p_pkt !== 3'd1) begin failures++; $display("FAIL flush_pre_pkt: got %0d expected 1", p_pkt); end
        checks++; if (p_dst.t_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b expected 1", p_dst.t_valid); end
        @(negedge clk);
        p_flush = 1'b1;
        p_drive(1'b1, mk_beat(99, 1'b1));
        p_dst.t_ready = 1'b1;
        #1;
        checks++; if (p_src.t_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0", p_src.t_ready); end
        checks++; if (p_dst.t_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", p_dst.t_valid); end
        @(negedge clk);
        p_flush = 1'b0;
        p_drive(1'b0, '0);
        p_dst.t_ready = 1'b0;
        #1;
        checks++; if (p_level !== 3'd0) begin failures++; $display("FAIL flush_level: got %0d expected 0", p_level); end
        checks++; if (p_pkt !== 3'd0) begin failures++; $display("FAIL flush_pkt: got %0d expected 0", p_pkt); end
        checks++; if (p_ae !== 1'b1) begin failures++; $display("FAIL flush_aempty: got %b expected 1", p_ae); end
        checks++; if (p_dst.t_valid !== 1'b0) begin failures++; $display("FAIL flush_post_valid: got %b expected 0", p_dst.t_valid); end
    endtask

    task automatic test_reset_mid();
        beat_t a5, obs;
        int seen = 0;
        a5      = '0;
        a5.data = 64'hA5;
        a5.strb = '1;
        a5.keep = '1;
        a5.last = 1'b1;
        s_dst.t_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_drive(1'b1, mk_beat(48 + k, 1'b0));
        end
        @(negedge clk);
        s_drive(1'b0, '0);
        #1;
        checks++; if (s_level !== 3'd2) begin failures++; $display("FAIL rstmid_pre_level: got %0d expected 2", s_level); end
        #2 areset = 1'b1;
        #1;
        checks++; if (s_level !== 3'd0) begin failures++; $display("FAIL rstmid_level: got %0d expected 0", s_level); end
        checks++; if (s_dst.t_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b expected 0", s_dst.t_valid); end
        checks++; if (s_src.t_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready: got %b expected 0", s_src.t_ready); end
        checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got ae=%b af=%b expected ae=1 af=0", s_ae, s_af); end
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        s_drive(1'b1, a5);
        s_dst.t_ready = 1'b1;
        #1;
        checks++; if (s_dst.t_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale_valid: got %b expected 0", s_dst.t_valid); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            s_drive(1'b0, '0);
            #1;
            if (s_dst.t_valid === 1'b1) begin
                seen++;
                obs = s_obs();
                checks++; if (obs !== a5) begin failures++; $display("FAIL rstmid_beat: got %h expected %h", obs, a5); end
            end
        end
        checks++; if (seen !== 1) begin failures++; $display("FAIL rstmid_beat_count: got %0d expected 1", seen); end
        s_dst.t_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        areset  = 1'b1;
        s_flush = 1'b0;
        p_flush = 1'b0;
        s_drive(1'b0, '0);
        p_drive(1'b0, '0);
        s_dst.t_ready = 1'b0;
        p_dst.t_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_fill_drain();
        test_stream_random(12, 60, 60, "wrap");
        test_stream_random(30, 100, 100, "back_to_back");
        test_stream_random(30, 100, 35, "near_full");
        test_packet();
        test_oversize();
        test_packet_random(10);
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
